// File: rtl/sw_enable_pulse_if.sv
// Pushbutton conditioner signal bundle.
// Raw button in, debounced strobes/level out.
interface sw_enable_pulse_if;
  logic SW_IN;
  logic SW_T_EN;
  logic SW_LEVEL;
  logic SW_LONG;

  modport master (
    output SW_IN,
    input  SW_T_EN,
    input  SW_LEVEL,
    input  SW_LONG
  );

  modport slave (
    input  SW_IN,
    output SW_T_EN,
    output SW_LEVEL,
    output SW_LONG
  );
endinterface

// File: rtl/sw_enable_pulse.sv
// Pushbutton conditioner: sync, debounce,
// one-shot press strobe, level, long-press strobe.
module sw_enable_pulse #(
  parameter int DEB_CYCLES  = 4,
  parameter int LONG_CYCLES = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input logic           CLK,
  input logic           RESET,
  sw_enable_pulse_if.slave sw
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT =
    HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  logic          q1;
  logic          q2;
  logic          s_sw;
  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          t_en_q;
  logic          t_en_nxt;
  logic          long_q;
  logic          long_nxt;
  logic          level_q;
  logic          level_nxt;

  // Two-flop synchroniser; polarity fixed up front
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= sw.SW_IN ^ ACTIVE_LOW;
      q2 <= q1;
    end
  end

  assign s_sw = q2;

  // Debounce FSM: next state, counters, strobes
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    t_en_nxt  = 1'b0;
    long_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_sw) begin
          state_nxt = DEB_PRESS;
          deb_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s_sw) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          hold_nxt  = '0;
          t_en_nxt  = 1'b1;
        end else begin
          deb_nxt = deb_cnt + DW'(1);
        end
      end
      HELD: begin
        if (!s_sw) begin
          state_nxt = DEB_REL;
          deb_nxt   = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          long_nxt = 1'b1;
          hold_nxt = HOLD_SAT;
        end else if (hold_cnt < HOLD_LAST) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      DEB_REL: begin
        // a bounce back to pressed keeps the
        // press alive and its hold time frozen
        if (s_sw) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          deb_nxt = deb_cnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    level_nxt = (state_nxt == HELD) ||
                (state_nxt == DEB_REL);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      t_en_q   <= 1'b0;
      long_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      hold_cnt <= hold_nxt;
      t_en_q   <= t_en_nxt;
      long_q   <= long_nxt;
      level_q  <= level_nxt;
    end
  end

  assign sw.SW_T_EN  = t_en_q;
  assign sw.SW_LONG  = long_q;
  assign sw.SW_LEVEL = level_q;

  // the two strobes come from exclusive states
  a_excl: assert property (
    @(posedge CLK) !(t_en_q && long_q)
  );

  // level tracks the pressed-side states
  a_level: assert property (
    @(posedge CLK) level_q ==
      ((state == HELD) || (state == DEB_REL))
  );

endmodule
